// File: rtl/dot_product_mac_if.sv
// Stream and result handshake bundle for dot_product_mac.
// slave: the MAC engine; master: the beat producer / result consumer.
interface dot_product_mac_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 16
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [LANES*DATA_W-1:0]   A;
  logic [LANES*DATA_W-1:0]   B;
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_W-1:0]          result;
  logic [CNT_W-1:0]          beat_count;
  logic                      overflow;

  modport slave (
    input  in_valid, in_last, A, B, out_ready,
    output in_ready, out_valid, result, beat_count, overflow
  );

  modport master (
    output in_valid, in_last, A, B, out_ready,
    input  in_ready, out_valid, result, beat_count, overflow
  );
endinterface

// File: rtl/dot_product_mac.sv
// Streaming dot-product MAC: multiply stage, lane reduction, accumulate, held result.
// Define DOTMAC_SAT_EN to saturate the accumulator instead of wrapping.
module dot_product_mac #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LANES  = 2,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  dot_product_mac_if.slave  bus
);
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
  localparam int unsigned EXT_W  = ACC_W + 1;

  logic              adv;
  logic [PROD_W-1:0] prod_d [LANES];
  logic [PROD_W-1:0] prod_q [LANES];
  logic              s1_valid_q, s1_last_q;
  logic [SUM_W-1:0]  sum_d, sum_q;
  logic              s2_valid_q, s2_last_q;

  logic [ACC_W-1:0]  acc_q, acc_d, acc_new;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_new;
  logic              ovf_q, ovf_d, ovf_new;
  logic [EXT_W-1:0]  acc_sum;
  logic              carry;
  logic              fire3;

  logic [ACC_W-1:0]  result_q, result_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d;
  logic              rovf_q, rovf_d;
  logic              out_valid_q, out_valid_d;

  // Everything holds while a finished result waits for its consumer.
  assign adv          = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = adv && !rst;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = PROD_W'(bus.A[i*DATA_W +: DATA_W]) * PROD_W'(bus.B[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
  end

  // S1 products and S2 lane sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      sum_q      <= '0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else if (adv) begin
      s1_valid_q <= bus.in_valid;
      s1_last_q  <= bus.in_last;
      for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      sum_q      <= sum_d;
    end
  end

  // Accumulator state is zero at the start of every vector, so acc_q is the base directly.
  assign acc_sum = {1'b0, acc_q} + EXT_W'(sum_q);
  assign carry   = acc_sum[ACC_W];
  assign ovf_new = ovf_q | carry;
  assign cnt_new = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef DOTMAC_SAT_EN
  assign acc_new = ovf_new ? '1 : acc_sum[ACC_W-1:0];
`else
  assign acc_new = acc_sum[ACC_W-1:0];
`endif
  assign fire3 = adv && s2_valid_q;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    bcnt_d      = bcnt_q;
    rovf_d      = rovf_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (fire3) begin
      if (s2_last_q) begin
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        result_d    = acc_new;
        bcnt_d      = cnt_new;
        rovf_d      = ovf_new;
        out_valid_d = 1'b1;
      end else begin
        acc_d = acc_new;
        cnt_d = cnt_new;
        ovf_d = ovf_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      bcnt_q      <= '0;
      rovf_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      bcnt_q      <= bcnt_d;
      rovf_q      <= rovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.beat_count = bcnt_q;
  assign bus.overflow   = rovf_q;
endmodule
